// File: rtl/leaf_stream_tx.sv
// Leaf transmit path: frames user words into BFT packets, holds bounced packets, gates on credits.
// Latency: word acked at edge N is on dout in the following cycle when idle with credit available.
// Backpressure: ack drops when the ingress FIFO is full; LEAF_TX_STATS_EN adds sent/resend counters.
module leaf_stream_tx #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_CREDIT    = 128,
  parameter int CREDIT_PORT   = 0
) (
  input  logic                     clk_bft,
  input  logic                     reset_bft,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface
`ifdef LEAF_TX_STATS_EN
  ,
  output logic [31:0]              pkt_sent_cnt,
  output logic [31:0]              resend_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_CREDIT + 1);
  localparam int SW = CW + 2;
  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam logic [SW-1:0] MAX_SUM = SW'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [PAYLOAD_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [PAYLOAD_BITS-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [CW-1:0]            credit_q, credit_d;
  logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
  logic [NUM_LEAF_BITS-1:0] dst_leaf_q, dst_leaf_d;
  logic [NUM_PORT_BITS-1:0] dst_port_q, dst_port_d;

  logic          fifo_full, push, busy, consume, ret_hit;
  logic [7:0]    ret_amt;
  logic [SW-1:0] credit_sum;

  always_comb begin
    fifo_full = (count_q == (AW + 1)'(FIFO_DEPTH));
    push      = vld_user2interface & ~fifo_full & ~reset_bft;
    busy      = (state_q != IDLE);
    consume   = busy & ~resend;
    ret_hit   = din_leaf_bft2interface[PACKET_BITS-1] &&
                (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CREDIT_PORT));
    ret_amt   = ret_hit ? din_leaf_bft2interface[7:0] : 8'd0;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din_leaf_user2interface;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(consume);
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(consume);

    // Consume and return in the same cycle net out before saturating.
    credit_sum = SW'(credit_q) - SW'(consume) + SW'(ret_amt);
    credit_d   = (credit_sum > MAX_SUM) ? CW'(MAX_CREDIT) : credit_sum[CW-1:0];
    seq_d      = seq_q + NUM_ADDR_BITS'(consume);

    state_d    = state_q;
    dst_leaf_d = dst_leaf_q;
    dst_port_d = dst_port_q;
    if (!busy || consume) begin
      state_d = ((count_d != '0) && (credit_d != '0)) ? SEND : IDLE;
      // A new packet starts: latch its destination for the whole bounce sequence.
      if (state_d == SEND) begin
        dst_leaf_d = dst_leaf;
        dst_port_d = dst_port;
      end
    end else begin
      state_d = HOLD;
    end

    ack_interface2user      = push;
    dout_leaf_interface2bft = busy ? {1'b1, dst_leaf_q, dst_port_q, seq_q, mem_q[rd_ptr_q]}
                                   : '0;
  end

  always_ff @(posedge clk_bft or posedge reset_bft) begin
    if (reset_bft) begin
      state_q    <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= CW'(MAX_CREDIT);
      seq_q      <= '0;
      dst_leaf_q <= '0;
      dst_port_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      seq_q      <= seq_d;
      dst_leaf_q <= dst_leaf_d;
      dst_port_q <= dst_port_d;
    end
  end

`ifdef LEAF_TX_STATS_EN
  logic [31:0] pkt_sent_q, pkt_sent_d, resend_cnt_q, resend_cnt_d;

  always_comb begin
    pkt_sent_d   = pkt_sent_q + 32'(consume);
    resend_cnt_d = resend_cnt_q + 32'(busy & resend);
    pkt_sent_cnt = pkt_sent_q;
    resend_cnt   = resend_cnt_q;
  end

  always_ff @(posedge clk_bft or posedge reset_bft) begin
    if (reset_bft) begin
      pkt_sent_q   <= '0;
      resend_cnt_q <= '0;
    end else begin
      pkt_sent_q   <= pkt_sent_d;
      resend_cnt_q <= resend_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_stream_tx.sv
// Directed + randomized bench for leaf_stream_tx against a queue-based transaction model.
module tb_leaf_stream_tx;

  logic        clk_bft = 1'b0;
  logic        reset_bft;
  logic [31:0] din_leaf_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic [4:0]  dst_leaf;
  logic [3:0]  dst_port;
  logic [48:0] dout_leaf_interface2bft;
  logic        resend;
  logic [48:0] din_leaf_bft2interface;
`ifdef LEAF_TX_STATS_EN
  logic [31:0] pkt_sent_cnt;
  logic [31:0] resend_cnt;
`endif

  leaf_stream_tx dut (
    .clk_bft                 (clk_bft),
    .reset_bft               (reset_bft),
    .din_leaf_user2interface (din_leaf_user2interface),
    .vld_user2interface      (vld_user2interface),
    .ack_interface2user      (ack_interface2user),
    .dst_leaf                (dst_leaf),
    .dst_port                (dst_port),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .resend                  (resend),
    .din_leaf_bft2interface  (din_leaf_bft2interface)
`ifdef LEAF_TX_STATS_EN
    ,
    .pkt_sent_cnt            (pkt_sent_cnt),
    .resend_cnt              (resend_cnt)
`endif
  );

  always #5 clk_bft = ~clk_bft;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: words waiting in the interface, the packet on the wire, credits.
  int unsigned mq[$];
  int unsigned uq[$];
  bit          m_active;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  int          m_seq;
  int          m_credit;
  int unsigned m_sent;
  int unsigned m_rs;

  bit          want_en = 1'b0;
  logic [48:0] want_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] exp_dout();
    logic [6:0]  s;
    logic [31:0] p;
    s = 7'(m_seq);
    p = m_active ? mq[0] : 32'd0;
    return m_active ? {1'b1, m_leaf, m_port, s, p} : 49'd0;
  endfunction

  function automatic logic [48:0] credit_pkt(input int amt, input logic [3:0] port, input logic v);
    logic [7:0] a;
    a = 8'(amt);
    return {v, 5'd9, port, 7'd0, 24'd0, a};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_seq    = 0;
    m_credit = 128;
    m_sent   = 0;
    m_rs     = 0;
    m_leaf   = '0;
    m_port   = '0;
  endtask

  // One clock cycle, entered at posedge+1: drive, check at negedge, advance model at posedge.
  task automatic step(input logic [48:0] bft, input logic rs);
    bit exp_ack;
    bit consumed;
    int ret;
    vld_user2interface      = (uq.size() > 0);
    din_leaf_user2interface = vld_user2interface ? uq[0] : $urandom;
    din_leaf_bft2interface  = bft;
    resend                  = rs;
    exp_ack = vld_user2interface && (mq.size() < 4);
    @(negedge clk_bft);
    check("ack", 64'(ack_interface2user), 64'(exp_ack));
    check("dout", 64'(dout_leaf_interface2bft), 64'(exp_dout()));
    check("credit", 64'(dut.credit_q), 64'(m_credit));
    if (want_en) check("dout_fixed", 64'(dout_leaf_interface2bft), 64'(want_dout));
`ifdef LEAF_TX_STATS_EN
    check("pkt_sent_cnt", 64'(pkt_sent_cnt), 64'(m_sent));
    check("resend_cnt", 64'(resend_cnt), 64'(m_rs));
`endif
    @(posedge clk_bft);
    consumed = m_active && !rs;
    if (m_active && rs) m_rs++;
    ret = (bft[48] && bft[42:39] == 4'd0) ? int'(bft[7:0]) : 0;
    m_credit = m_credit - int'(consumed) + ret;
    if (m_credit > 128) m_credit = 128;
    if (consumed) begin
      void'(mq.pop_front());
      m_seq = (m_seq + 1) % 128;
      m_sent++;
    end
    if (exp_ack) mq.push_back(uq.pop_front());
    if (!m_active || consumed) begin
      m_active = (mq.size() > 0) && (m_credit > 0);
      if (m_active) begin
        m_leaf = dst_leaf;
        m_port = dst_port;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_bft          = 1'b1;
    vld_user2interface = 1'b1;
    #1;
    check("rst_dout", 64'(dout_leaf_interface2bft), 64'd0);
    check("rst_ack", 64'(ack_interface2user), 64'd0);
`ifdef LEAF_TX_STATS_EN
    check("rst_pkt_sent", 64'(pkt_sent_cnt), 64'd0);
    check("rst_resend", 64'(resend_cnt), 64'd0);
`endif
    model_reset();
    uq.delete();
    @(posedge clk_bft);
    #1;
    reset_bft          = 1'b0;
    vld_user2interface = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (uq.size() > 0 || m_active); i++) step('0, 1'b0);
  endtask

  initial begin
    int hold_cnt;
    reset_bft = 1'b1;
    vld_user2interface = 1'b1;
    din_leaf_user2interface = '0;
    dst_leaf = '0;
    dst_port = '0;
    resend = 1'b0;
    din_leaf_bft2interface = '0;
    #4;
    check("por_dout", 64'(dout_leaf_interface2bft), 64'd0);
    check("por_ack", 64'(ack_interface2user), 64'd0);
    check("por_credit", 64'(dut.credit_q), 64'd128);
    model_reset();
    @(posedge clk_bft);
    #1;
    reset_bft = 1'b0;
    vld_user2interface = 1'b0;

    // Single word: fixed expected frame, then idle, credit 127.
    dst_leaf = 5'd3;
    dst_port = 4'd2;
    uq.push_back(32'hDEADBEEF);
    step('0, 1'b0);
    want_en = 1'b1;
    want_dout = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
    step('0, 1'b0);
    want_dout = 49'd0;
    step('0, 1'b0);
    want_en = 1'b0;

    // Six back-to-back words; seq 4 is bounced three times.
    do_reset();
    for (int i = 0; i < 6; i++) uq.push_back($urandom);
    hold_cnt = 0;
    for (int i = 0; i < 40 && (uq.size() > 0 || m_active); i++) begin
      logic rs;
      rs = m_active && (m_seq == 4) && (hold_cnt < 3);
      if (rs) hold_cnt++;
      step('0, rs);
    end

    // Long bounce with continuous user traffic fills the FIFO; dst changes mid-hold.
    for (int i = 0; i < 8; i++) uq.push_back($urandom);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        dst_leaf = 5'd17;
        dst_port = 4'd9;
      end
      step('0, 1'b1);
    end
    drain(40);

    // Exhaust credit, then a return of 8 releases the stranded word.
    do_reset();
    for (int i = 0; i < 129; i++) uq.push_back($urandom);
    drain(300);
    for (int i = 0; i < 3; i++) step('0, 1'b0);
    step(credit_pkt(8, 4'd0, 1'b1), 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);

    // Credit saturation, ignored packets, and return coinciding with consume.
    step(credit_pkt(93, 4'd0, 1'b1), 1'b0);
    step(credit_pkt(200, 4'd0, 1'b1), 1'b0);
    step(credit_pkt(50, 4'd3, 1'b1), 1'b0);
    step(credit_pkt(50, 4'd0, 1'b0), 1'b0);
    uq.push_back($urandom);
    for (int i = 0; i < 4; i++) step(m_active ? credit_pkt(1, 4'd0, 1'b1) : 49'd0, 1'b0);

    // Asynchronous reset while a packet is being bounced.
    uq.push_back($urandom);
    for (int i = 0; i < 4; i++) step('0, 1'b1);
    uq.push_back($urandom);
    do_reset();
    uq.push_back(32'h0000_1234);
    for (int i = 0; i < 3; i++) step('0, 1'b0);

    // Randomized traffic with bounces, credit returns, noise packets and dst changes.
    for (int i = 0; i < 600; i++) begin
      logic [48:0] bft;
      int sel;
      if (uq.size() == 0 && $urandom_range(9, 0) < 6) uq.push_back($urandom);
      if ($urandom_range(19, 0) == 0) begin
        dst_leaf = 5'($urandom);
        dst_port = 4'($urandom);
      end
      sel = int'($urandom_range(5, 0));
      case (sel)
        0: bft = credit_pkt(int'($urandom_range(3, 1)), 4'd0, 1'b1);
        1: bft = credit_pkt(int'($urandom_range(255, 0)), 4'($urandom_range(15, 1)), 1'b1);
        2: bft = credit_pkt(int'($urandom_range(255, 0)), 4'd0, 1'b0);
        default: bft = '0;
      endcase
      step(bft, ($urandom_range(9, 0) < 3));
    end
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
